dac_burst_ctrl: RTL and testbench

Sequences the DAC sample stream for triggered burst playback. Sits between the waveform sources (DDS / arbitrary-waveform buffer) and the DAC output driver. It gates, counts and repeats bursts of A/B sample pairs, and drives mid-scale whenever playback is not active. Software configures and arms it, and an external trigger starts playback.

---
 rtl/dac_burst_ctrl_if.sv | 38 +++
 rtl/dac_burst_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dac_burst_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_burst_ctrl_if.sv
// Control, configuration, source and DAC-side signals of the burst controller.
// The master drives configuration, control and source data; the slave is the controller.
interface dac_burst_ctrl_if #(
    parameter int unsigned DW    = 14,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned RPT_W = 16
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_burst_len;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_gap;
    logic [RPT_W-1:0] cfg_repeat;
    logic             arm;
    logic             abort;
    logic             trig_in;
    logic             src_valid;
    logic [DW-1:0]    src_data_a;
    logic [DW-1:0]    src_data_b;
    logic             src_ready;
    logic [DW-1:0]    dac_data_a;
    logic [DW-1:0]    dac_data_b;
    logic             busy;
    logic             done;
    logic             underrun;
    logic [2:0]       state_o;

    modport master (
        output cfg_valid, cfg_burst_len, cfg_delay, cfg_gap, cfg_repeat,
        output arm, abort, trig_in, src_valid, src_data_a, src_data_b,
        input  src_ready, dac_data_a, dac_data_b, busy, done, underrun, state_o
    );

    modport slave (
        input  cfg_valid, cfg_burst_len, cfg_delay, cfg_gap, cfg_repeat,
        input  arm, abort, trig_in, src_valid, src_data_a, src_data_b,
        output src_ready, dac_data_a, dac_data_b, busy, done, underrun, state_o
    );
endinterface

// File: rtl/dac_burst_ctrl.sv
// Triggered burst sequencer for the DAC sample stream: gates, counts and repeats
// bursts of A/B sample pairs and drives mid-scale whenever playback is inactive.
module dac_burst_ctrl #(
    parameter int unsigned   DW        = 14,
    parameter int unsigned   CNT_W     = 32,
    parameter int unsigned   RPT_W     = 16,
    parameter logic [DW-1:0] IDLE_CODE = DW'(14'h2000)
) (
    input  logic              clk_dac,
    input  logic              rst_n,
    dac_burst_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_RUN   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, delay_q, gap_q;
    logic [RPT_W-1:0] repeat_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_last;
    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
    logic             done_pend_q, done_pend_d, done_q;
    logic             trig_d, trig_edge, arm_ok, underrun_q;
    logic [DW-1:0]    data_a_q, data_b_q;

    // A zero burst length plays a single sample; repeat count saturates in infinite mode
    assign len_last  = (len_q == '0) ? '0 : len_q - CNT_W'(1);
    assign rpt_inc   = (rpt_q == '1) ? rpt_q : rpt_q + RPT_W'(1);
    assign trig_edge = bus.trig_in & ~trig_d;
    assign arm_ok    = (state_q == ST_IDLE) & bus.arm & ~bus.abort;

    // State register; done is delayed one extra cycle so it follows the last output sample
    always_ff @(posedge clk_dac or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rpt_q       <= '0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            done_pend_q <= done_pend_d;
            done_q      <= done_pend_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rpt_d       = rpt_q;
        done_pend_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arm_ok) begin
                    state_d = ST_ARMED;
                    rpt_d   = '0;
                end
            end
            ST_ARMED: begin
                cnt_d = '0;
                if (trig_edge) state_d = (delay_q != '0) ? ST_DELAY : ST_RUN;
            end
            ST_DELAY: begin
                if (cnt_q == delay_q - CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cnt_q == len_last) begin
                    cnt_d = '0;
                    rpt_d = rpt_inc;
                    if ((repeat_q != '0) && (rpt_inc == repeat_q)) begin
                        state_d     = ST_IDLE;
                        done_pend_d = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == gap_q - CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (bus.abort) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            done_pend_d = 1'b0;
        end
    end

    // Configuration is only accepted while idle so a running burst keeps its settings
    always_ff @(posedge clk_dac or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            delay_q  <= '0;
            gap_q    <= '0;
            repeat_q <= '0;
        end else if (bus.cfg_valid && (state_q == ST_IDLE)) begin
            len_q    <= bus.cfg_burst_len;
            delay_q  <= bus.cfg_delay;
            gap_q    <= bus.cfg_gap;
            repeat_q <= bus.cfg_repeat;
        end
    end

    always_ff @(posedge clk_dac or negedge rst_n) begin
        if (!rst_n) trig_d <= 1'b0;
        else        trig_d <= bus.trig_in;
    end

    // Output stage: source data only on live RUN cycles, mid-scale otherwise
    always_ff @(posedge clk_dac or negedge rst_n) begin
        if (!rst_n) begin
            data_a_q <= IDLE_CODE;
            data_b_q <= IDLE_CODE;
        end else if ((state_q == ST_RUN) && bus.src_valid && !bus.abort) begin
            data_a_q <= bus.src_data_a;
            data_b_q <= bus.src_data_b;
        end else begin
            data_a_q <= IDLE_CODE;
            data_b_q <= IDLE_CODE;
        end
    end

    always_ff @(posedge clk_dac or negedge rst_n) begin
        if (!rst_n)                                                      underrun_q <= 1'b0;
        else if (arm_ok)                                                 underrun_q <= 1'b0;
        else if ((state_q == ST_RUN) && !bus.src_valid && !bus.abort)    underrun_q <= 1'b1;
    end

    assign bus.src_ready  = (state_q == ST_RUN);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.state_o    = state_q;
    assign bus.dac_data_a = data_a_q;
    assign bus.dac_data_b = data_b_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_dac_burst_ctrl.sv
// Directed bench for dac_burst_ctrl: per-cycle expectations come from hand-built
// RUN/valid/trigger masks indexed by clock interval after the arming sequence.
module tb_dac_burst_ctrl;

    localparam int unsigned DW    = 14;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned RPT_W = 16;
    localparam logic [DW-1:0] IDLE = 14'h2000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    dac_burst_ctrl_if #(.DW(DW), .CNT_W(CNT_W), .RPT_W(RPT_W)) bus ();

    dac_burst_ctrl #(.DW(DW), .CNT_W(CNT_W), .RPT_W(RPT_W), .IDLE_CODE(IDLE)) dut (
        .clk_dac (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic load_cfg(input int len, input int dly, input int gap, input int rpt);
        bus.cfg_burst_len = CNT_W'(len);
        bus.cfg_delay     = CNT_W'(dly);
        bus.cfg_gap       = CNT_W'(gap);
        bus.cfg_repeat    = RPT_W'(rpt);
        bus.cfg_valid     = 1'b1;
        tick();
        bus.cfg_valid     = 1'b0;
    endtask

    task automatic arm_pulse(input string tag);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check_eq({tag, "_armed"}, 32'(bus.state_o), 32'd1);
    endtask

    // Interval i precedes edge i; src_a carries i so each output slot names its source cycle.
    task automatic play(input string tag, input int n, input logic [127:0] run_m,
                        input logic [127:0] val_m, input logic [127:0] trg_m,
                        input int done_at, input int abort_at, input int poke_at);
        logic exp_ur = 1'b0;
        logic live;
        for (int i = 0; i < n; i++) begin
            bus.trig_in    = trg_m[i];
            bus.src_valid  = val_m[i];
            bus.src_data_a = DW'(i);
            bus.src_data_b = DW'(i + 'h100);
            bus.abort      = (i == abort_at);
            bus.cfg_valid  = (i == poke_at);
            if (i == poke_at) begin
                bus.cfg_burst_len = CNT_W'(5);
                bus.cfg_delay     = '0;
                bus.cfg_gap       = '0;
                bus.cfg_repeat    = RPT_W'(1);
            end
            tick();
            live = run_m[i] && (i != abort_at);
            if (live && !val_m[i]) exp_ur = 1'b1;
            check_eq($sformatf("%s_rdy%0d", tag, i), 32'(bus.src_ready), 32'(run_m[i+1]));
            check_eq($sformatf("%s_a%0d", tag, i), 32'(bus.dac_data_a),
                     (live && val_m[i]) ? 32'(i) : 32'(IDLE));
            check_eq($sformatf("%s_b%0d", tag, i), 32'(bus.dac_data_b),
                     (live && val_m[i]) ? 32'(i + 'h100) : 32'(IDLE));
            check_eq($sformatf("%s_done%0d", tag, i), 32'(bus.done), 32'(i == done_at));
            check_eq($sformatf("%s_ur%0d", tag, i), 32'(bus.underrun), 32'(exp_ur));
        end
        bus.trig_in   = 1'b0;
        bus.src_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_burst_len = '0;
        bus.cfg_delay     = '0;
        bus.cfg_gap       = '0;
        bus.cfg_repeat    = '0;
        bus.arm           = 1'b0;
        bus.abort         = 1'b0;
        bus.trig_in       = 1'b0;
        bus.src_valid     = 1'b0;
        bus.src_data_a    = '0;
        bus.src_data_b    = '0;
        repeat (3) tick();

        check_eq("rst_state", 32'(bus.state_o), 32'd0);
        check_eq("rst_a", 32'(bus.dac_data_a), 32'(IDLE));
        check_eq("rst_b", 32'(bus.dac_data_b), 32'(IDLE));
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_ur", 32'(bus.underrun), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rdy", 32'(bus.src_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single burst of four, no delay
        load_cfg(4, 0, 0, 1);
        arm_pulse("t1");
        play("t1", 8, span(1, 4), '1, '1, 5, -1, -1);
        check_eq("t1_idle", 32'(bus.state_o), 32'd0);

        // Delay 3, two bursts of two separated by a gap of two
        load_cfg(2, 3, 2, 2);
        arm_pulse("t2");
        play("t2", 13, span(4, 5) | span(8, 9), '1, '1, 10, -1, -1);

        // Underrun on the third RUN cycle, sticky until the next arm
        load_cfg(5, 0, 0, 1);
        arm_pulse("t3");
        play("t3", 9, span(1, 5), ~(128'(1) << 3), '1, 6, -1, -1);
        tick();
        check_eq("t3_sticky", 32'(bus.underrun), 32'd1);

        // Infinite back-to-back bursts of three, stopped by abort
        load_cfg(3, 0, 0, 0);
        check_eq("t3_held", 32'(bus.underrun), 32'd1);
        arm_pulse("t4");
        check_eq("t3_clear", 32'(bus.underrun), 32'd0);
        play("t4", 106, span(1, 101), '1, '1, -1, 101, -1);
        check_eq("t4_state", 32'(bus.state_o), 32'd0);
        check_eq("t4_busy", 32'(bus.busy), 32'd0);

        // Re-trigger during DELAY and cfg_valid during RUN must both be ignored
        load_cfg(2, 2, 1, 2);
        arm_pulse("t5a");
        play("t5a", 11, span(3, 4) | span(6, 7), '1, 128'b101, 8, -1, 3);

        // arm together with abort leaves the controller idle
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        check_eq("t5b_state", 32'(bus.state_o), 32'd0);
        bus.trig_in = 1'b1;
        tick();
        bus.trig_in = 1'b0;
        tick();
        check_eq("t5b_notrig", 32'(bus.state_o), 32'd0);

        // Trigger already high at arm: only a fresh rising edge starts playback
        load_cfg(2, 0, 0, 1);
        bus.trig_in = 1'b1;
        tick();
        arm_pulse("t5c");
        repeat (2) tick();
        check_eq("t5c_hold", 32'(bus.state_o), 32'd1);
        play("t5c", 7, span(2, 3), '1, ~128'(1), 4, -1, -1);

        // Asynchronous reset in the middle of a burst
        load_cfg(8, 0, 0, 1);
        arm_pulse("t6");
        bus.trig_in    = 1'b1;
        bus.src_valid  = 1'b1;
        bus.src_data_a = DW'(5);
        bus.src_data_b = DW'(6);
        tick();
        tick();
        check_eq("t6_run", 32'(bus.state_o), 32'd3);
        check_eq("t6_data", 32'(bus.dac_data_a), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_a", 32'(bus.dac_data_a), 32'(IDLE));
        check_eq("t6_rst_b", 32'(bus.dac_data_b), 32'(IDLE));
        check_eq("t6_rst_state", 32'(bus.state_o), 32'd0);
        check_eq("t6_rst_rdy", 32'(bus.src_ready), 32'd0);
        tick();
        rst_n         = 1'b1;
        bus.trig_in   = 1'b0;
        bus.src_valid = 1'b0;
        tick();

        // Zero length plays one sample
        load_cfg(0, 0, 0, 1);
        arm_pulse("t7");
        play("t7", 5, span(1, 1), '1, '1, 2, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
